// File: rtl/multi_initiator.sv
// Requester-side sequencer for single-outstanding start/done units: issues one
// operand, waits for done under a watchdog, and returns result plus wait count.
//
//   state   | meaning
//   IDLE    | ready for a new request
//   ISSUE   | start pulse to the unit, counter loaded
//   WAIT    | waiting for done or watchdog expiry
//   RESP    | response held until consumed
module multi_initiator #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   output logic             start,
   output logic [WIDTH-1:0] inp,
   input  logic             done,
   input  logic [WIDTH-1:0] out,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_timeout,
   output logic [7:0]       resp_cycles,
   output logic             stray_done
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t           r_state;
   state_t           w_next;
   logic [7:0]       r_cnt;
   logic [WIDTH-1:0] r_inp;
   logic [WIDTH-1:0] r_resp_data;
   logic             r_resp_timeout;
   logic [7:0]       r_resp_cycles;
   logic             r_stray;
   logic             w_expired;

   assign w_expired = (r_cnt == TIMEOUT_C);

   always_ff @(posedge clock) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid)             w_next = S_ISSUE;
         S_ISSUE:                            w_next = S_WAIT;
         S_WAIT:  if (done || w_expired)     w_next = S_RESP;
         S_RESP:  if (resp_ready)            w_next = S_IDLE;
         default:                            w_next = S_IDLE;
      endcase
   end

   // req_ready is masked while reset is asserted, since the state already reads IDLE then
   always_comb begin
      req_ready  = reset_n && (r_state == S_IDLE);
      start      = (r_state == S_ISSUE);
      resp_valid = (r_state == S_RESP);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_cnt          <= 8'd0;
         r_inp          <= '0;
         r_resp_data    <= '0;
         r_resp_timeout <= 1'b0;
         r_resp_cycles  <= 8'd0;
         r_stray        <= 1'b0;
      end else begin
         if (r_state == S_IDLE && req_valid) r_inp <= req_data;
         case (r_state)
            S_ISSUE: r_cnt <= 8'd1;
            S_WAIT: begin
               // done wins over the watchdog when both land in the same cycle
               if (done) begin
                  r_resp_data    <= out;
                  r_resp_timeout <= 1'b0;
                  r_resp_cycles  <= r_cnt;
               end else if (w_expired) begin
                  r_resp_data    <= '0;
                  r_resp_timeout <= 1'b1;
                  r_resp_cycles  <= TIMEOUT_C;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
         if (done && (r_state == S_IDLE || r_state == S_RESP)) r_stray <= 1'b1;
      end
   end

   assign inp          = r_inp;
   assign resp_data    = r_resp_data;
   assign resp_timeout = r_resp_timeout;
   assign resp_cycles  = r_resp_cycles;
   assign stray_done   = r_stray;

endmodule

// File: tb/tb_multi_initiator.sv
// Bench for multi_initiator: table of transactions, hand-written back-to-back and
// reset-in-WAIT sequences, then random transactions against a transaction-level model.
module tb_multi_initiator;

   localparam int TMO = 15;

   logic        clock;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_data;
   logic        start;
   logic [31:0] inp;
   logic        done;
   logic [31:0] out;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_timeout;
   logic [7:0]  resp_cycles;
   logic        stray_done;

   int n_vec = 0;
   int n_mis = 0;
   bit exp_stray = 0;

   multi_initiator #(.WIDTH(32), .TIMEOUT(TMO)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_data     (req_data),
      .start        (start),
      .inp          (inp),
      .done         (done),
      .out          (out),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_timeout (resp_timeout),
      .resp_cycles  (resp_cycles),
      .stray_done   (stray_done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_mis);
      $fatal(1);
   end

   typedef struct {
      logic [31:0] op;
      int          k;          // done delay after start; 0 = never
      logic [31:0] res;
      int          bp;         // cycles of resp_ready=0
      bit          bp_done;    // pulse done while held in RESP
      bit          issue_done; // drive done during the start cycle
      int          lat;
      logic        to;
      logic [7:0]  cy;
      logic [31:0] d;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_inp", inp, 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_timeout", 32'(resp_timeout), 32'd0);
      chk("rst_resp_cycles", 32'(resp_cycles), 32'd0);
      chk("rst_stray_done", 32'(stray_done), 32'd0);
      exp_stray = 0;
   endtask

   // Called and returns at a negedge; outputs are sampled first, then inputs for the same cycle are driven.
   task automatic do_txn(input vec_t v);
      int g;
      int lat;
      int nst;
      req_valid = 1'b1;
      req_data  = v.op;
      g = 0;
      while (!req_ready && g < 50) begin
         @(negedge clock);
         g++;
      end
      chk("accept_ready", 32'(req_ready), 32'd1);
      @(negedge clock);
      req_valid = 1'b0;
      chk("start_pulse", 32'(start), 32'd1);
      chk("start_inp", inp, v.op);
      chk("busy_not_ready", 32'(req_ready), 32'd0);
      done = v.issue_done;
      out  = v.res;
      lat  = -1;
      nst  = 0;
      for (int j = 2; j < 300; j++) begin
         @(negedge clock);
         done = 1'b0;
         if (start) nst++;
         if (resp_valid) begin
            lat = j;
            break;
         end
         if (req_ready) nst = nst + 100;
         done = (j == v.k + 1);
      end
      done = 1'b0;
      chk("extra_start_or_ready", 32'(nst), 32'd0);
      chk("latency", 32'(lat), 32'(v.lat));
      chk("resp_data", resp_data, v.d);
      chk("resp_timeout", 32'(resp_timeout), 32'(v.to));
      chk("resp_cycles", 32'(resp_cycles), 32'(v.cy));
      resp_ready = 1'b0;
      for (int b = 0; b < v.bp; b++) begin
         done = v.bp_done && (b == v.bp / 2);
         if (done) exp_stray = 1;
         @(negedge clock);
         done = 1'b0;
         chk("bp_valid", 32'(resp_valid), 32'd1);
         chk("bp_data", resp_data, v.d);
         chk("bp_timeout", 32'(resp_timeout), 32'(v.to));
         chk("bp_cycles", 32'(resp_cycles), 32'(v.cy));
      end
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      chk("post_ready", 32'(req_ready), 32'd1);
      chk("post_valid", 32'(resp_valid), 32'd0);
      chk("post_inp", inp, v.op);
      chk("stray_done", 32'(stray_done), 32'(exp_stray));
   endtask

   // Expected response from the transaction rules alone: done within the window wins, otherwise the watchdog.
   function automatic vec_t model(input logic [31:0] op, input int k, input logic [31:0] res,
                                  input int bp, input bit bpd, input bit isd);
      vec_t v;
      bit   tmo;
      tmo          = (k == 0) || (k > TMO);
      v.op         = op;
      v.k          = k;
      v.res        = res;
      v.bp         = bp;
      v.bp_done    = bpd;
      v.issue_done = isd;
      v.to         = tmo;
      v.cy         = tmo ? 8'(TMO) : 8'(k);
      v.d          = tmo ? 32'd0 : res;
      v.lat        = 2 + int'(v.cy);
      return v;
   endfunction

   task automatic back_to_back();
      int   n_start = 0;
      int   n_acc = 0;
      int   n_resp = 0;
      int   c_resp1 = -1;
      int   c_acc2 = -1;
      logic prev_start = 1'b0;
      logic [31:0] rd [2];
      rd[0] = 32'd0;
      rd[1] = 32'd0;
      req_valid  = 1'b1;
      req_data   = 32'd1;
      resp_ready = 1'b1;
      for (int c = 0; c < 24; c++) begin
         if (n_acc == 1) req_data = 32'd2;
         if (n_acc == 2) req_valid = 1'b0;
         if (start) begin
            n_start++;
            chk("b2b_start_width", 32'(prev_start), 32'd0);
            chk("b2b_start_inp", inp, 32'(n_start));
         end
         if (resp_valid) begin
            if (n_resp < 2) rd[n_resp] = resp_data;
            if (n_resp == 0) c_resp1 = c;
            n_resp++;
         end
         if (req_ready && req_valid) begin
            n_acc++;
            if (n_acc == 2) c_acc2 = c;
         end
         done       = prev_start;
         out        = inp + 32'd100;
         prev_start = start;
         @(negedge clock);
      end
      done       = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      chk("b2b_starts", 32'(n_start), 32'd2);
      chk("b2b_resps", 32'(n_resp), 32'd2);
      chk("b2b_resp0", rd[0], 32'd101);
      chk("b2b_resp1", rd[1], 32'd102);
      chk("b2b_second_accept", 32'(c_acc2), 32'(c_resp1 + 1));
   endtask

   task automatic reset_in_wait();
      req_valid = 1'b1;
      req_data  = 32'h0000_0077;
      chk("rw_ready", 32'(req_ready), 32'd1);
      @(negedge clock);               // T+1
      req_valid = 1'b0;
      chk("rw_start", 32'(start), 32'd1);
      repeat (3) @(negedge clock);    // T+4: WAIT with counter 3
      chk("rw_waiting", 32'(resp_valid | req_ready), 32'd0);
      reset_n = 1'b0;
      @(negedge clock);
      chk_reset_vals();
      reset_n = 1'b1;
      @(negedge clock);
      chk("rw_ready_after", 32'(req_ready), 32'd1);
      chk("rw_no_resp", 32'(resp_valid), 32'd0);
      done = 1'b1;                    // late done from the abandoned operation
      @(negedge clock);
      done = 1'b0;
      exp_stray = 1;
      chk("rw_stray", 32'(stray_done), 32'd1);
      chk("rw_still_idle", 32'(req_ready), 32'd1);
      chk("rw_no_resp2", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_data   = 32'd0;
      done       = 1'b0;
      out        = 32'd0;
      resp_ready = 1'b0;

      tbl[0] = '{32'hDEADBEEF, 2,  32'hDEADBEEF, 0, 1'b0, 1'b0, 4,  1'b0, 8'd2,  32'hDEADBEEF};
      tbl[1] = '{32'h12345678, 0,  32'h11111111, 0, 1'b0, 1'b0, 17, 1'b1, 8'd15, 32'h0};
      tbl[2] = '{32'hCAFE0001, 15, 32'h00C0FFEE, 1, 1'b0, 1'b1, 17, 1'b0, 8'd15, 32'h00C0FFEE};
      tbl[3] = '{32'h00000042, 16, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 17, 1'b1, 8'd15, 32'h0};
      tbl[4] = '{32'h80000001, 1,  32'h7FFFFFFE, 2, 1'b0, 1'b0, 3,  1'b0, 8'd1,  32'h7FFFFFFE};
      tbl[5] = '{32'hA5A5A5A5, 3,  32'h5A5A5A5A, 5, 1'b1, 1'b0, 5,  1'b0, 8'd3,  32'h5A5A5A5A};

      repeat (3) @(negedge clock);
      chk_reset_vals();
      reset_n = 1'b1;
      @(negedge clock);
      chk("release_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 6; i++) do_txn(tbl[i]);

      back_to_back();
      reset_in_wait();
      do_txn(model(32'h0BADF00D, 4, 32'h600DF00D, 0, 1'b0, 1'b0));

      for (int i = 0; i < 40; i++) begin
         do_txn(model($urandom, int'($urandom_range(0, TMO + 2)), $urandom,
                      int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1))));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
